// File: rtl/sck_divider.sv
// ---------------------------------------------------------------------------
// sck_divider
//   Qualifies the PLL lock flag and divides the PLL output clock down to a
//   programmable serial clock. SPI shift logic should use the sck_rise /
//   sck_fall strobes rather than sck itself, so that it stays synchronous
//   to clock_in.
//
// Parameters
//   DIV_WIDTH   width of the half-period divisor
//   LOCK_STABLE synchronised-locked cycles required before ready (>= 1)
//   CPOL        idle level of sck
//
// Ports
//   clock_in  in   PLL output clock, all logic on its rising edge
//   reset     in   synchronous, active-high reset
//   locked    in   PLL lock flag (asynchronous)
//   div       in   half-period length minus 1, in clock_in cycles
//   enable    in   request to run sck
//   sck       out  divided serial clock (registered)
//   sck_rise  out  one-cycle pulse in the cycle sck becomes 1
//   sck_fall  out  one-cycle pulse in the cycle sck becomes 0
//   ready     out  lock qualified
//   active    out  divider running (RUN or DRAIN)
// ---------------------------------------------------------------------------
module sck_divider #(
  parameter int DIV_WIDTH   = 8,
  parameter int LOCK_STABLE = 1024,
  parameter bit CPOL        = 1'b0
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 locked,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 enable,
  output logic                 sck,
  output logic                 sck_rise,
  output logic                 sck_fall,
  output logic                 ready,
  output logic                 active
);

  localparam int            CW       = $clog2(LOCK_STABLE + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_STABLE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // All divider state lives in one record so the next-state logic can start
  // from "hold everything" and only touch what changes.
  typedef struct packed {
    state_t               st;
    logic [DIV_WIDTH-1:0] div_l;
    logic [DIV_WIDTH-1:0] hc;
    logic                 sck;
    logic                 rise;
    logic                 fall;
  } div_reg_t;

  localparam div_reg_t RST = '{st: IDLE, div_l: '0, hc: '0, sck: CPOL,
                               rise: 1'b0, fall: 1'b0};

  // -------------------------------------------------------------------------
  // Lock qualification
  // -------------------------------------------------------------------------
  logic [1:0]    lk_pipe;
  logic          lk_s;
  logic [CW-1:0] lk_cnt;
  logic          ready_d;

  assign lk_s = lk_pipe[1];

  always_ff @(posedge clock_in) begin
    if (reset) lk_pipe <= '0;
    else       lk_pipe <= {lk_pipe[0], locked};
  end

  // Saturating run-length of lk_s; any low cycle restarts the window.
  always_ff @(posedge clock_in) begin
    if (reset)                  lk_cnt <= '0;
    else if (!lk_s)             lk_cnt <= '0;
    else if (lk_cnt != LOCK_MAX) lk_cnt <= lk_cnt + CW'(1);
  end

  // ready_d is the value ready takes on the coming edge. The FSM looks at it
  // so that a lock loss stops the divider on the same edge ready drops.
  assign ready_d = lk_s && (lk_cnt == LOCK_MAX);

  always_ff @(posedge clock_in) begin
    if (reset) ready <= 1'b0;
    else       ready <= ready_d;
  end

  // -------------------------------------------------------------------------
  // Divider FSM
  // -------------------------------------------------------------------------
  div_reg_t cur, nx;
  logic     period_start;

  // First cycle of a period: sck at its idle level and nothing counted yet.
  // Stopping here cuts no edge short, so a low enable can leave at once.
  assign period_start = (cur.sck == CPOL) && (cur.hc == '0);

  always_ff @(posedge clock_in) begin
    if (reset) cur <= RST;
    else       cur <= nx;
  end

  always_comb begin
    nx      = cur;
    nx.rise = 1'b0;
    nx.fall = 1'b0;
    unique case (cur.st)
      IDLE: begin
        nx.sck = CPOL;
        nx.hc  = '0;
        if (ready && ready_d && enable) begin
          nx.st    = RUN;
          nx.div_l = div;
        end
      end
      RUN, DRAIN: begin
        if (!ready_d) begin
          // Lock lost: abandon the period, no strobe for the forced level.
          nx.st  = IDLE;
          nx.sck = CPOL;
          nx.hc  = '0;
        end else if (!enable && period_start) begin
          nx.st = IDLE;
        end else begin
          // RUN and DRAIN divide identically; enable only picks which one we
          // are in, so re-enabling during DRAIN costs no gap and no edge.
          nx.st = enable ? RUN : DRAIN;
          if (cur.hc == cur.div_l) begin
            nx.hc   = '0;
            nx.sck  = ~cur.sck;
            nx.rise = ~cur.sck;
            nx.fall = cur.sck;
            // Toggle back to the idle level closes a period: only here may a
            // new divisor take effect.
            if (cur.sck != CPOL) nx.div_l = div;
          end else begin
            nx.hc = cur.hc + DIV_WIDTH'(1);
          end
        end
      end
      default: nx = RST;
    endcase
  end

  assign sck      = cur.sck;
  assign sck_rise = cur.rise;
  assign sck_fall = cur.fall;
  assign active   = (cur.st != IDLE);

endmodule

// File: tb/tb_sck_divider.sv
module tb_sck_divider;

  localparam int DW = 8;
  localparam int LS = 8;

  logic          clk = 1'b0;
  logic          reset, locked, enable;
  logic [DW-1:0] div;
  logic          sck0, rise0, fall0, ready0, active0;
  logic          sck1, rise1, fall1, ready1, active1;

  always #5 clk = ~clk;

  sck_divider #(.DIV_WIDTH(DW), .LOCK_STABLE(LS), .CPOL(1'b0)) u_dut0 (
    .clock_in(clk), .reset(reset), .locked(locked), .div(div), .enable(enable),
    .sck(sck0), .sck_rise(rise0), .sck_fall(fall0), .ready(ready0), .active(active0));

  sck_divider #(.DIV_WIDTH(DW), .LOCK_STABLE(LS), .CPOL(1'b1)) u_dut1 (
    .clock_in(clk), .reset(reset), .locked(locked), .div(div), .enable(enable),
    .sck(sck1), .sck_rise(rise1), .sck_fall(fall1), .ready(ready1), .active(active1));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Strobe scoreboard for the CPOL=0 instance: expected (cycle, direction).
  typedef struct {
    int cyc;
    bit rise;
  } ev_t;
  ev_t sb[$];

  task automatic push_ev(input int c, input bit r);
    ev_t e;
    e.cyc  = c;
    e.rise = r;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  logic prev_sck0;

  always @(negedge clk) begin
    if (mon_en) begin
      // CPOL=1 instance must be the exact inverse of the CPOL=0 one.
      chk("cpol1_mirror", {sck1, rise1, fall1, ready1, active1},
                          {~sck0, fall0, rise0, ready0, active0});
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL strobe_missed cyc=%0d want_at=%0d rise=%0d",
                 cyc, sb[0].cyc, sb[0].rise);
        void'(sb.pop_front());
      end
      if (rise0 || fall0) begin
        chk("strobe_excl", rise0 & fall0, 0);
        chk("strobe_active", active0, 1);
        chk("strobe_level", sck0, rise0);
        chk("strobe_toggle", prev_sck0 ^ sck0, 1);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL strobe_unexpected cyc=%0d got rise=%0d fall=%0d want none",
                   cyc, rise0, fall0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("strobe_cyc", cyc, e.cyc);
          chk("strobe_dir", rise0, e.rise);
        end
      end
      if (ready0 && (sck0 !== prev_sck0))
        chk("toggle_has_strobe", {rise0, fall0}, {sck0, !sck0});
      prev_sck0 <= sck0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit    lk;
    int    dly;
    bit    exp_rdy;
    string nm;
  } lk_vec_t;
  lk_vec_t lv[8];

  initial begin
    int n;
    // drive locked, wait dly cycles, then check ready
    lv[0] = '{1'b1, 10, 1'b0, "lk_pre_qual"};
    lv[1] = '{1'b1, 1,  1'b1, "lk_qual"};
    lv[2] = '{1'b1, 8,  1'b1, "lk_hold"};
    lv[3] = '{1'b0, 1,  1'b1, "lk_drop_sync1"};
    lv[4] = '{1'b1, 1,  1'b1, "lk_drop_sync2"};
    lv[5] = '{1'b1, 1,  1'b0, "lk_drop_seen"};
    lv[6] = '{1'b1, 8,  1'b0, "lk_requal_early"};
    lv[7] = '{1'b1, 1,  1'b1, "lk_requal"};

    reset = 1'b1; locked = 1'b0; enable = 1'b0; div = '0;
    repeat (3) @(negedge clk);
    chk("rst_sck0", sck0, 0);
    chk("rst_sck1", sck1, 1);
    chk("rst_strobes", {rise0, fall0, rise1, fall1}, 0);
    chk("rst_ready", {ready0, ready1}, 0);
    chk("rst_active", {active0, active1}, 0);
    reset = 1'b0;
    prev_sck0 = sck0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // ---- lock qualification table ----
    for (int i = 0; i < 8; i++) begin
      locked = lv[i].lk;
      repeat (lv[i].dly) @(negedge clk);
      chk(lv[i].nm, ready0, lv[i].exp_rdy);
      chk("lk_no_active", active0, 0);
    end
    repeat (2) @(negedge clk);

    // ---- div=2: period 6, drain after a rise ----
    n = cyc; div = 8'd2; enable = 1'b1;
    for (int k = 1; k <= 6; k++) push_ev(n + 1 + 3*k, (k % 2) == 1);
    wait_until(n + 5);  chk("a_active", active0, 1);
    wait_until(n + 16); enable = 1'b0;
    wait_until(n + 19); chk("a_drain_active", active0, 1);
    wait_until(n + 20); chk("a_idle", active0, 0); chk("a_sck_idle", sck0, 0);
    repeat (3) @(negedge clk);

    // ---- div=0 then div=3 set mid high phase ----
    n = cyc; div = 8'd0; enable = 1'b1;
    push_ev(n + 2, 1); push_ev(n + 3, 0); push_ev(n + 4, 1); push_ev(n + 5, 0);
    push_ev(n + 9, 1); push_ev(n + 13, 0);
    wait_until(n + 4);  div = 8'd3;
    wait_until(n + 9);  enable = 1'b0;
    wait_until(n + 13); chk("b_drain_active", active0, 1);
    wait_until(n + 14); chk("b_idle", active0, 0);
    repeat (3) @(negedge clk);

    // ---- div=4: re-enable during drain, then a real drain ----
    n = cyc; div = 8'd4; enable = 1'b1;
    push_ev(n + 6, 1); push_ev(n + 11, 0); push_ev(n + 16, 1);
    push_ev(n + 21, 0); push_ev(n + 26, 1); push_ev(n + 31, 0);
    wait_until(n + 17); enable = 1'b0;
    wait_until(n + 19); chk("c_in_drain", active0, 1); enable = 1'b1;
    wait_until(n + 27); enable = 1'b0;
    wait_until(n + 31); chk("c_fall_active", active0, 1);
    wait_until(n + 32); chk("c_idle", active0, 0); chk("c_sck_idle", sck0, 0);
    wait_until(n + 40); chk("c_sck_stays", sck0, 0);

    // ---- lock loss mid high phase ----
    n = cyc; div = 8'd4; enable = 1'b1;
    push_ev(n + 6, 1);
    wait_until(n + 6);  chk("d_cpol1_first_fall", {sck1, fall1, rise1}, 3'b010);
    wait_until(n + 7);  locked = 1'b0;
    wait_until(n + 9);  chk("d_still_high", {sck0, active0}, 2'b11);
    wait_until(n + 10);
    chk("d_sck_forced", sck0, 0);
    chk("d_no_fall", fall0, 0);
    chk("d_active", active0, 0);
    chk("d_ready", ready0, 0);
    chk("d_sck1_idle", sck1, 1);
    enable = 1'b0; locked = 1'b1;
    wait_until(n + 20); chk("d_relock_early", ready0, 0);
    wait_until(n + 21); chk("d_relock", ready0, 1);
    repeat (3) @(negedge clk);

    // ---- div all ones: half period 256 ----
    n = cyc; div = 8'hFF; enable = 1'b1;
    push_ev(n + 257, 1); push_ev(n + 513, 0);
    wait_until(n + 300); enable = 1'b0;
    wait_until(n + 513); chk("e_fall_active", active0, 1);
    wait_until(n + 514); chk("e_idle", active0, 0);
    repeat (3) @(negedge clk);

    // ---- reset mid run ----
    n = cyc; div = 8'd1; enable = 1'b1;
    push_ev(n + 3, 1); push_ev(n + 5, 0); push_ev(n + 7, 1);
    wait_until(n + 8); reset = 1'b1;
    wait_until(n + 9);
    chk("f_sck", sck0, 0);
    chk("f_strobes", {rise0, fall0}, 0);
    chk("f_ready", ready0, 0);
    chk("f_active", active0, 0);
    chk("f_sck1", sck1, 1);
    reset = 1'b0; enable = 1'b0;
    wait_until(n + 19); chk("f_requal_early", ready0, 0);
    wait_until(n + 20); chk("f_requal", ready0, 1);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sck_divider.md
Name: sck_divider

Overview:
- Clock-divider/strobe generator on the PLL output clock: clock multiplication happens upstream, division happens here.
- Qualifies the PLL `locked` flag (synchronise plus stability window), then divides `clock_in` down to a programmable serial clock `sck`.
- Emits single-cycle `sck_rise`/`sck_fall` strobes so SPI shift logic stays fully synchronous to `clock_in`.
- Sits between the PLL wrapper and the SPI engine.

Parameters:
- DIV_WIDTH, 8, width of the half-period divisor input.
- LOCK_STABLE, 1024, consecutive synchronised `locked`-high cycles required before `ready` asserts. Must be at least 1.
- CPOL, 0, idle level of `sck`.

Ports:
- clock_in  input  1  PLL output clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- locked  input  1  PLL lock flag, asynchronous to this block.
- div  input  DIV_WIDTH  half-period length minus 1, in `clock_in` cycles.
- enable  input  1  request to run `sck`.
- sck  output  1  divided serial clock; registered.
- sck_rise  output  1  one-cycle pulse, asserted in the same cycle `sck` becomes 1.
- sck_fall  output  1  one-cycle pulse, asserted in the same cycle `sck` becomes 0.
- ready  output  1  lock qualified, stable for LOCK_STABLE cycles.
- active  output  1  divider is running (RUN or DRAIN).

Behaviour:
- Reset, all state: `sck`=CPOL, `sck_rise`=`sck_fall`=`ready`=`active`=0, state IDLE, all counters 0, sync flops 0.
- Lock synchroniser: `locked` passes through 2 flops to give `lk_s` (2-cycle latency).
- Lock counter:
  - Increments while `lk_s`=1 and saturates at LOCK_STABLE.
  - `ready` is registered and asserts on the cycle after the counter reaches LOCK_STABLE.
  - Any cycle with `lk_s`=0 clears the counter to 0 and deasserts `ready` on the next edge.
- FSM states IDLE, RUN, DRAIN:
  - IDLE: `sck`=CPOL, no strobes. When `ready`&&`enable`: latch `div` into `div_l`, clear the half-period counter `hc`, go to RUN.
  - RUN: `hc` counts 0..`div_l`. At `hc`==`div_l`: toggle `sck`, pulse the matching strobe, set `hc`=0.
  - Period boundary = a toggle that returns `sck` to CPOL. At each boundary `div_l` reloads from `div`; a mid-period `div` change never alters the current period.
  - If `enable`=0 is sampled in RUN, go to DRAIN.
  - DRAIN: keep toggling until the next period boundary, then go to IDLE.
  - If `enable` re-asserts during DRAIN, return to RUN with no gap and no extra edge.
- Half period = `div`+1 cycles; full period = 2·(`div`+1).
  - `div`=0 gives `sck` = `clock_in`/2.
  - `div`=all-ones gives half period 2^DIV_WIDTH.
  - `hc` is DIV_WIDTH bits and never exceeds `div_l`.
- Lock loss: when `ready` falls in RUN or DRAIN, go to IDLE on that same edge. `sck` is forced to CPOL with no strobe, even mid-period. This truncates the period, which is intended; downstream must abort its transfer.
- `active`=1 exactly in RUN and DRAIN.
- Strobes are mutually exclusive and never assert in IDLE.
- Reset asserted mid-operation: all outputs return to their reset values on the next edge, and the lock window restarts from 0.

Test Plan:
1. LOCK_STABLE=8, `locked` rises at cycle 10 → `ready`=1 at cycle 10+2+8+1=21. `locked` pulsed low for 1 cycle at cycle 30 → `ready`=0 by cycle 33, then re-qualifies after 8 more stable cycles.
2. CPOL=0, `div`=2, `enable`=1 after `ready` → `sck` toggles every 3 cycles (period 6). `sck_rise` coincides with each 0→1 and `sck_fall` with each 1→0. Exactly 1 strobe per toggle.
3. `div`=0 → `sck` alternates every cycle with strobes alternating rise/fall. Changing `div` to 3 mid-high-phase → current period completes at the old rate, next full period is 8 cycles.
4. `enable` dropped while `sck`=1, `div`=4 → `sck` completes its high phase, falls with `sck_fall`, `active`=0 next cycle, `sck` stays 0. Repeat with `enable` restored during DRAIN → no gap, period unchanged.
5. `locked` dropped mid-high-phase while running → `sck`=CPOL within 3 cycles, no `sck_fall` pulse, `active`=0. CPOL=1 variant: `sck` idles 1, first edge is `sck_fall`.
6. `reset` asserted mid-RUN → next edge `sck`=CPOL, `ready`=0, `active`=0. After release, `ready` requires the full LOCK_STABLE window again.
